// File: rtl/aes_pkg.sv
// Shared AES-128 constants and GF(2^8) helpers for the iterative encryption core.
// Holds the state encoding, S-box, Rcon, xtime, MixColumns and SubWord.
package aes_pkg;

    localparam int AES_NR    = 10;
    localparam int AES_BLK_W = 128;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } aes_state_e;

    // Forward S-box, entry x at bits [2047-8x -: 8].
    localparam logic [2047:0] AES_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return AES_SBOX[2047 - 8*int'(x) -: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        logic [7:0] v;
        case (idx)
            4'd0:    v = 8'h01;
            4'd1:    v = 8'h02;
            4'd2:    v = 8'h04;
            4'd3:    v = 8'h08;
            4'd4:    v = 8'h10;
            4'd5:    v = 8'h20;
            4'd6:    v = 8'h40;
            4'd7:    v = 8'h80;
            4'd8:    v = 8'h1b;
            4'd9:    v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

endpackage

// File: rtl/aes_round_step.sv
// One combinational AES-128 round: on-the-fly key expansion, SubBytes,
// ShiftRows, optional MixColumns and AddRoundKey with the freshly expanded key.
module aes_round_step
    import aes_pkg::*;
(
    input  logic [127:0] i_state,
    input  logic [127:0] i_rkey,
    input  logic [3:0]   i_rnd,
    input  logic         i_final,
    output logic [127:0] o_state,
    output logic [127:0] o_rkey
);

    logic [31:0]  w_temp;
    logic [31:0]  w_k0, w_k1, w_k2, w_k3;
    logic [127:0] w_sr;
    logic [127:0] w_mc;

    // Next round key from the previous one, Rcon indexed by round-1
    always_comb begin
        w_temp = sub_word({i_rkey[23:0], i_rkey[31:24]}) ^ {rcon(i_rnd - 4'd1), 24'h000000};
        w_k0   = i_rkey[127:96] ^ w_temp;
        w_k1   = i_rkey[95:64]  ^ w_k0;
        w_k2   = i_rkey[63:32]  ^ w_k1;
        w_k3   = i_rkey[31:0]   ^ w_k2;
    end

    // SubBytes and ShiftRows; byte index is row + 4*column
    always_comb begin
        w_sr = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                w_sr[127 - 8*(r + 4*c) -: 8] = sbox(i_state[127 - 8*(r + 4*((c + r) % 4)) -: 8]);
            end
        end
    end

    // MixColumns, bypassed in the last round
    always_comb begin
        w_mc = '0;
        for (int c = 0; c < 4; c++) begin
            if (i_final) begin
                w_mc[127 - 32*c -: 32] = w_sr[127 - 32*c -: 32];
            end else begin
                w_mc[127 - 32*c -: 32] = mix_col(w_sr[127 - 32*c -: 32]);
            end
        end
    end

    assign o_rkey  = {w_k0, w_k1, w_k2, w_k3};
    assign o_state = w_mc ^ o_rkey;

endmodule

// File: rtl/aes_iter_core.sv
// Iterative AES-128 encryption core: ROUNDS_PER_CYCLE chained round steps per
// clock, round keys expanded on the fly, valid/ready handshakes on both sides.
module aes_iter_core
    import aes_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [AES_BLK_W-1:0] in_block,
    input  logic [AES_BLK_W-1:0] in_key,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [AES_BLK_W-1:0] out_block,
    output logic                 busy
);

    localparam int R = ROUNDS_PER_CYCLE;

    generate
        if (R != 1 && R != 2 && R != 5 && R != 10) begin : g_bad_rpc
            $error("aes_iter_core: ROUNDS_PER_CYCLE must be 1, 2, 5 or 10");
        end
    endgenerate

    aes_state_e             r_state;
    aes_state_e             w_next_state;
    logic [AES_BLK_W-1:0]   r_blk;
    logic [AES_BLK_W-1:0]   r_key;
    logic [3:0]             r_rnd;
    logic                   w_load;
    logic                   w_step;
    logic                   w_last;
    logic [AES_BLK_W-1:0]   w_state_chain [0:R];
    logic [AES_BLK_W-1:0]   w_key_chain   [0:R];

    assign w_state_chain[0] = r_blk;
    assign w_key_chain[0]   = r_key;

    generate
        for (genvar g = 0; g < R; g++) begin : g_step
            aes_round_step u_step (
                .i_state (w_state_chain[g]),
                .i_rkey  (w_key_chain[g]),
                .i_rnd   (r_rnd + 4'(g)),
                .i_final ((r_rnd + 4'(g)) == 4'(AES_NR)),
                .o_state (w_state_chain[g+1]),
                .o_rkey  (w_key_chain[g+1])
            );
        end
    endgenerate

    // Reset is folded in so nothing looks acceptable while rst is held
    assign in_ready  = (r_state == ST_IDLE) && !rst;
    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state != ST_IDLE);
    assign out_block = r_blk;
    assign w_last    = (r_rnd + 4'(R - 1)) == 4'(AES_NR);

    // Next-state and datapath enables
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    w_next_state = ST_RUN;
                    w_load       = 1'b1;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_RUN: begin
                w_step = 1'b1;
                if (w_last) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_RUN;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_DONE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // State, block, key and round registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_blk   <= '0;
            r_key   <= '0;
            r_rnd   <= 4'd0;
        end else begin
            r_state <= w_next_state;
            if (w_load) begin
                r_blk <= in_block ^ in_key;
                r_key <= in_key;
                r_rnd <= 4'd1;
            end else if (w_step) begin
                r_blk <= w_state_chain[R];
                r_key <= w_key_chain[R];
                r_rnd <= r_rnd + 4'(R);
            end else begin
                r_blk <= r_blk;
                r_key <= r_key;
                r_rnd <= r_rnd;
            end
        end
    end

endmodule

// File: tb/tb_aes_iter_core.sv
// Self-checking bench for aes_iter_core: one instance per legal ROUNDS_PER_CYCLE,
// FIPS-197 vectors, handshake corner cases and random blocks against an AES model.
module tb_aes_iter_core;

    localparam int NI = 4;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid  [NI];
    logic         in_ready  [NI];
    logic [127:0] in_block  [NI];
    logic [127:0] in_key    [NI];
    logic         out_valid [NI];
    logic         out_ready [NI];
    logic [127:0] out_block [NI];
    logic         busy      [NI];

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic [7:0] sb [256];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    generate
        for (genvar g = 0; g < NI; g++) begin : g_dut
            aes_iter_core #(.ROUNDS_PER_CYCLE(g == 0 ? 1 : g == 1 ? 2 : g == 2 ? 5 : 10)) u_dut (
                .clk       (clk),
                .rst       (rst),
                .in_valid  (in_valid[g]),
                .in_ready  (in_ready[g]),
                .in_block  (in_block[g]),
                .in_key    (in_key[g]),
                .out_valid (out_valid[g]),
                .out_ready (out_ready[g]),
                .out_block (out_block[g]),
                .busy      (busy[g])
            );
        end
    endgenerate

    function automatic int rof(input int k);
        case (k)
            0:       return 1;
            1:       return 2;
            2:       return 5;
            default: return 10;
        endcase
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse then affine map
    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sb[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                  ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] ref_aes(input logic [127:0] pt, input logic [127:0] key);
        logic [7:0]  s [16];
        logic [7:0]  t [16];
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rc = 8'h01;
        logic [7:0]  a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h000000};
                rc  = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ key[127 - 8*i -: 8];
        for (int rd = 1; rd <= 10; rd++) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[r + 4*c] = sb[s[r + 4*((c + r) % 4)]];
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                if (rd < 10) begin
                    s[4*c]   = gmul(8'h02, a0) ^ gmul(8'h03, a1) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(8'h02, a1) ^ gmul(8'h03, a2) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(8'h02, a2) ^ gmul(8'h03, a3);
                    s[4*c+3] = gmul(8'h03, a0) ^ a1 ^ a2 ^ gmul(8'h02, a3);
                end else begin
                    s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
                end
                for (int r = 0; r < 4; r++) s[r + 4*c] = s[r + 4*c] ^ w[4*rd + c][31 - 8*r -: 8];
            end
        end
        for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
        return res;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one block, wait for the result; returns result, latency and accept cycle
    task automatic run_block(input int k, input logic [127:0] pt, input logic [127:0] key,
                             input bit churn, output logic [127:0] res, output int lat,
                             output int acc);
        int g = 0;
        while (!in_ready[k] && g < 50) begin
            tick();
            g++;
        end
        chk($sformatf("ready_wait[%0d]", k), 128'(in_ready[k]), 128'(1));
        in_valid[k] = 1'b1;
        in_block[k] = pt;
        in_key[k]   = key;
        tick();
        acc = cyc;
        in_valid[k] = 1'b0;
        lat = 0;
        while (!out_valid[k] && lat < 40) begin
            if (churn) begin
                in_valid[k] = 1'($urandom_range(0, 1));
                in_block[k] = {$urandom(), $urandom(), $urandom(), $urandom()};
                in_key[k]   = {$urandom(), $urandom(), $urandom(), $urandom()};
            end
            tick();
            lat++;
        end
        in_valid[k] = 1'b0;
        res = out_block[k];
    endtask

    task automatic release_out(input int k);
        out_ready[k] = 1'b1;
        tick();
        out_ready[k] = 1'b0;
        chk($sformatf("idle_after_out[%0d]", k), 128'(in_ready[k]), 128'(1));
    endtask

    // Mutual exclusion of out_valid and in_ready on every instance
    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < NI; k++) begin
                n_assert++;
                assert (!(in_ready[k] && out_valid[k])) else begin
                    n_fail++;
                    $error("FAIL excl[%0d]: in_ready=%b out_valid=%b, both high", k, in_ready[k], out_valid[k]);
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] res;
        logic [127:0] exp;
        int lat, acc, prev_acc, nblk, st;
        bit seen, done;

        build_sbox();
        for (int k = 0; k < NI; k++) begin
            in_valid[k] = 1'b0; in_block[k] = '0; in_key[k] = '0; out_ready[k] = 1'b0;
        end

        // Reset state
        rst = 1'b1;
        in_valid[0] = 1'b1;
        repeat (3) tick();
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("rst_in_ready[%0d]", k),  128'(in_ready[k]),  128'(0));
            chk($sformatf("rst_out_valid[%0d]", k), 128'(out_valid[k]), 128'(0));
            chk($sformatf("rst_busy[%0d]", k),      128'(busy[k]),      128'(0));
            chk($sformatf("rst_out_block[%0d]", k), out_block[k],       128'(0));
        end
        in_valid[0] = 1'b0;
        rst = 1'b0;
        #1;
        for (int k = 0; k < NI; k++) chk($sformatf("post_rst_ready[%0d]", k), 128'(in_ready[k]), 128'(1));

        chk("model_appB", ref_aes(PT_B, KEY_B), CT_B);

        // App. B, R = 1
        run_block(0, PT_B, KEY_B, 1'b0, res, lat, acc);
        chk("appB_lat", 128'(lat), 128'(10));
        chk("appB_ct", res, CT_B);
        release_out(0);

        // App. C.1 on every R
        for (int k = 0; k < NI; k++) begin
            run_block(k, PT_C, KEY_C, 1'b0, res, lat, acc);
            chk($sformatf("appC_lat[R=%0d]", rof(k)), 128'(lat), 128'(10 / rof(k)));
            chk($sformatf("appC_ct[R=%0d]", rof(k)), res, CT_C);
            release_out(k);
        end

        // Output backpressure
        run_block(0, PT_B, KEY_B, 1'b0, res, lat, acc);
        for (int i = 0; i < 20; i++) begin
            chk("stall_block", out_block[0], CT_B);
            chk("stall_ready", 128'(in_ready[0]), 128'(0));
            chk("stall_busy", 128'(busy[0]), 128'(1));
            tick();
        end
        out_ready[0] = 1'b1;
        tick();
        out_ready[0] = 1'b0;
        chk("stall_release_ready", 128'(in_ready[0]), 128'(1));
        chk("stall_release_valid", 128'(out_valid[0]), 128'(0));

        // Inputs toggling during RUN are ignored
        run_block(0, PT_B, KEY_B, 1'b1, res, lat, acc);
        chk("churn_lat", 128'(lat), 128'(10));
        chk("churn_ct", res, CT_B);
        release_out(0);

        // Reset in RUN cycle 4
        in_valid[0] = 1'b1; in_block[0] = PT_C; in_key[0] = KEY_C;
        tick();
        in_valid[0] = 1'b0;
        repeat (3) tick();
        chk("pre_rst_busy", 128'(busy[0]), 128'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("midrst_ready", 128'(in_ready[0]), 128'(1));
        chk("midrst_busy", 128'(busy[0]), 128'(0));
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            seen = seen | out_valid[0];
            tick();
        end
        chk("midrst_no_output", 128'(seen), 128'(0));
        run_block(0, PT_C, KEY_C, 1'b0, res, lat, acc);
        chk("midrst_next_lat", 128'(lat), 128'(10));
        chk("midrst_next_ct", res, CT_C);
        release_out(0);

        // Back-to-back random blocks with random out_ready
        for (int k = 0; k < NI; k++) begin
            nblk = (k == 0) ? 1000 : 150;
            prev_acc = 0;
            for (int b = 0; b < nblk; b++) begin
                logic [127:0] pt;
                logic [127:0] key;
                pt  = {$urandom(), $urandom(), $urandom(), $urandom()};
                key = {$urandom(), $urandom(), $urandom(), $urandom()};
                exp = ref_aes(pt, key);
                run_block(k, pt, key, 1'b0, res, lat, acc);
                chk($sformatf("rnd_lat[R=%0d,%0d]", rof(k), b), 128'(lat), 128'(10 / rof(k)));
                chk($sformatf("rnd_ct[R=%0d,%0d]", rof(k), b), res, exp);
                if (b > 0) chk($sformatf("rnd_period[R=%0d,%0d]", rof(k), b),
                               128'((acc - prev_acc) >= (10 / rof(k) + 2)), 128'(1));
                prev_acc = acc;
                done = 1'b0;
                st = 0;
                while (!done) begin
                    out_ready[k] = (st >= 8) ? 1'b1 : 1'($urandom_range(0, 1));
                    chk($sformatf("rnd_hold[R=%0d,%0d]", rof(k), b), out_block[k], exp);
                    tick();
                    if (out_ready[k]) done = 1'b1;
                    st++;
                end
                out_ready[k] = 1'b0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
